boreal_weight_arbiter: RTL and testbench

Single-port arbiter and sequencer for the 1024×16 synaptic weight BRAM. It shares the BRAM among three requesters: the inference core's per-sample weight fetch, the Hebbian plasticity engine (read-modify-write), and the host configuration loader. The core path has strict priority and is never stalled. Hebbian writes are frozen while the AD-Guard interlock or the bite switch is active.

---
 rtl/boreal_pkg.sv | 13 +
 rtl/boreal_wt_age_ctr.sv | 32 +++
 rtl/boreal_weight_arbiter.sv | 144 ++++++++++++++
 tb/tb_boreal_weight_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_pkg.sv
// Shared constants and types for the synaptic weight memory subsystem.
package boreal_pkg;

  localparam int unsigned WT_ADDR_W = 10;
  localparam int unsigned WT_DATA_W = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_HEBB = 2'd2
  } req_tag_t;

endpackage

// File: rtl/boreal_wt_age_ctr.sv
// Saturating wait counter: counts cycles a request waits ungranted.
// The hit output is high once the count reaches MAX.
module boreal_wt_age_ctr
  import boreal_pkg::*;
#(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic hit
);

  localparam int unsigned AGE_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [AGE_W-1:0] LP_MAX = AGE_W'(MAX);

  logic [AGE_W-1:0] r_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (!req || gnt) begin
      r_age <= '0;
    end else if (r_age != LP_MAX) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign hit = (r_age == LP_MAX);

endmodule

// File: rtl/boreal_weight_arbiter.sv
// Single-port weight BRAM arbiter: core read (strict priority), Hebbian RMW
// with write freeze, and host config writes with age-based anti-starvation.
module boreal_weight_arbiter
  import boreal_pkg::*;
#(
  parameter int unsigned ADDR_W  = WT_ADDR_W,
  parameter int unsigned DATA_W  = WT_DATA_W,
  parameter int unsigned AGE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              hebb_req,
  input  logic              hebb_we,
  input  logic [ADDR_W-1:0] hebb_addr,
  input  logic [DATA_W-1:0] hebb_wdata,
  output logic              hebb_gnt,
  output logic [DATA_W-1:0] hebb_rdata,
  output logic              hebb_rvalid,
  input  logic              cfg_req,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_gnt,
  input  logic              ad_guard_active,
  input  logic              bite_switch_n,
  output logic              wr_freeze,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  logic              w_freeze;
  logic              w_hebb_elig;
  logic              w_cfg_hit;
  logic              w_hebb_gnt;
  logic              w_cfg_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  req_tag_t          w_tag;

  logic              r_wr_freeze;
  logic              r_bram_en;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_wdata;
  req_tag_t          r_tag1;
  req_tag_t          r_tag2;
  logic [DATA_W-1:0] r_core_rdata;
  logic              r_core_rvalid;
  logic [DATA_W-1:0] r_hebb_rdata;
  logic              r_hebb_rvalid;

  assign w_freeze    = ad_guard_active | ~bite_switch_n;
  // A frozen write simply loses eligibility; the requester keeps it pending.
  assign w_hebb_elig = hebb_req & ~(hebb_we & w_freeze);

  boreal_wt_age_ctr #(.MAX(AGE_MAX)) u_cfg_age (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (cfg_req),
    .gnt   (w_cfg_gnt),
    .hit   (w_cfg_hit)
  );

  always_comb begin
    w_hebb_gnt = 1'b0;
    w_cfg_gnt  = 1'b0;
    if (rst_n && !core_req) begin
      if (cfg_req && w_cfg_hit) begin
        w_cfg_gnt = 1'b1;
      end else if (w_hebb_elig) begin
        w_hebb_gnt = 1'b1;
      end else if (cfg_req) begin
        w_cfg_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr  = core_addr;
    w_wdata = '0;
    w_we    = 1'b0;
    w_tag   = TAG_NONE;
    if (core_req) begin
      w_tag = TAG_CORE;
    end else if (w_hebb_gnt) begin
      w_addr  = hebb_addr;
      w_wdata = hebb_wdata;
      w_we    = hebb_we;
      w_tag   = hebb_we ? TAG_NONE : TAG_HEBB;
    end else if (w_cfg_gnt) begin
      w_addr  = cfg_addr;
      w_wdata = cfg_wdata;
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_freeze   <= 1'b0;
      r_bram_en     <= 1'b0;
      r_bram_we     <= 1'b0;
      r_bram_addr   <= '0;
      r_bram_wdata  <= '0;
      r_tag1        <= TAG_NONE;
      r_tag2        <= TAG_NONE;
      r_core_rdata  <= '0;
      r_core_rvalid <= 1'b0;
      r_hebb_rdata  <= '0;
      r_hebb_rvalid <= 1'b0;
    end else begin
      r_wr_freeze   <= w_freeze;
      r_bram_en     <= core_req | w_hebb_gnt | w_cfg_gnt;
      r_bram_we     <= w_we;
      r_bram_addr   <= w_addr;
      r_bram_wdata  <= w_wdata;
      r_tag1        <= w_tag;
      r_tag2        <= r_tag1;
      r_core_rvalid <= (r_tag2 == TAG_CORE);
      r_hebb_rvalid <= (r_tag2 == TAG_HEBB);
      if (r_tag2 == TAG_CORE) r_core_rdata <= bram_rdata;
      if (r_tag2 == TAG_HEBB) r_hebb_rdata <= bram_rdata;
    end
  end

  assign hebb_gnt    = w_hebb_gnt;
  assign cfg_gnt     = w_cfg_gnt;
  assign wr_freeze   = r_wr_freeze;
  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_wdata  = r_bram_wdata;
  assign core_rdata  = r_core_rdata;
  assign core_rvalid = r_core_rvalid;
  assign hebb_rdata  = r_hebb_rdata;
  assign hebb_rvalid = r_hebb_rvalid;

endmodule

// File: tb/tb_boreal_weight_arbiter.sv
// Directed bench for boreal_weight_arbiter with a behavioural 1024x16 BRAM.
module tb_boreal_weight_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req;
  logic [9:0]  core_addr;
  logic [15:0] core_rdata;
  logic        core_rvalid;
  logic        hebb_req;
  logic        hebb_we;
  logic [9:0]  hebb_addr;
  logic [15:0] hebb_wdata;
  logic        hebb_gnt;
  logic [15:0] hebb_rdata;
  logic        hebb_rvalid;
  logic        cfg_req;
  logic [9:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_gnt;
  logic        ad_guard_active;
  logic        bite_switch_n;
  logic        wr_freeze;
  logic        bram_en;
  logic        bram_we;
  logic [9:0]  bram_addr;
  logic [15:0] bram_wdata;
  logic [15:0] bram_rdata = '0;

  logic [15:0] mem [0:1023];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      bram_rdata <= mem[bram_addr];
    end
  end

  boreal_weight_arbiter #(.ADDR_W(10), .DATA_W(16), .AGE_MAX(15)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req        (core_req),
    .core_addr       (core_addr),
    .core_rdata      (core_rdata),
    .core_rvalid     (core_rvalid),
    .hebb_req        (hebb_req),
    .hebb_we         (hebb_we),
    .hebb_addr       (hebb_addr),
    .hebb_wdata      (hebb_wdata),
    .hebb_gnt        (hebb_gnt),
    .hebb_rdata      (hebb_rdata),
    .hebb_rvalid     (hebb_rvalid),
    .cfg_req         (cfg_req),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_gnt         (cfg_gnt),
    .ad_guard_active (ad_guard_active),
    .bite_switch_n   (bite_switch_n),
    .wr_freeze       (wr_freeze),
    .bram_en         (bram_en),
    .bram_we         (bram_we),
    .bram_addr       (bram_addr),
    .bram_wdata      (bram_wdata),
    .bram_rdata      (bram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic freeze_seq(input bit use_bite, input logic [9:0] a, input logic [15:0] d);
    nxt();
    if (use_bite) bite_switch_n = 1'b0;
    else ad_guard_active = 1'b1;
    hebb_req = 1'b1; hebb_we = 1'b0; hebb_addr = 10'd2;
    #2 chk("frz_rd_gnt", 32'(hebb_gnt), 32'd1);
    chk("frz_lag0", 32'(wr_freeze), 32'd0);
    nxt();
    hebb_we = 1'b1; hebb_addr = a; hebb_wdata = d;
    #2 chk("frz_wr_gnt0", 32'(hebb_gnt), 32'd0);
    chk("frz_lag1", 32'(wr_freeze), 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      nxt();
      #2 chk("frz_stall_gnt", 32'(hebb_gnt), 32'd0);
      chk("frz_no_we", 32'(bram_we), 32'd0);
    end
    nxt();
    ad_guard_active = 1'b0; bite_switch_n = 1'b1;
    #2 chk("frz_release_gnt", 32'(hebb_gnt), 32'd1);
    chk("frz_still_reg", 32'(wr_freeze), 32'd1);
    nxt();
    hebb_req = 1'b0;
    #2 chk("frz_wr_issue", {bram_en, bram_we, 4'd0, bram_addr, bram_wdata}, {2'b11, 4'd0, a, d});
    chk("frz_cleared", 32'(wr_freeze), 32'd0);
  endtask

  task automatic aging(input bit with_core);
    nxt();
    cfg_req = 1'b1; cfg_addr = 10'd9; cfg_wdata = 16'h0909;
    hebb_req = 1'b1; hebb_we = 1'b0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (i > 0) nxt();
      hebb_addr = 10'(100 + i);
      #2 chk("age_wait", {30'd0, cfg_gnt, hebb_gnt}, 32'b01);
    end
    nxt();
    core_req = with_core; core_addr = 10'd0;
    if (with_core) begin
      #2 chk("age_core_wins", {30'd0, cfg_gnt, hebb_gnt}, 32'b00);
      nxt();
      core_req = 1'b0;
    end
    #2 chk("age_cfg_gnt", {30'd0, cfg_gnt, hebb_gnt}, 32'b10);
    nxt();
    cfg_req = 1'b0; hebb_req = 1'b0;
    #2 chk("age_cfg_issue", {bram_we, 5'd0, bram_addr, bram_wdata}, {1'b1, 5'd0, 10'd9, 16'h0909});
    repeat (4) nxt();
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 16'h0F0F; mem[1] = 16'h0101; mem[2] = 16'hA5A5; mem[5] = 16'h1234;
    rst_n = 1'b0;
    core_req = 1'b1; core_addr = 10'd5;
    hebb_req = 1'b1; hebb_we = 1'b1; hebb_addr = 10'd6; hebb_wdata = 16'h6666;
    cfg_req = 1'b1; cfg_addr = 10'd7; cfg_wdata = 16'h7777;
    ad_guard_active = 1'b1; bite_switch_n = 1'b1;

    for (int unsigned i = 0; i < 3; i++) begin
      nxt();
      #2 chk("rst_strobes", {27'd0, bram_en, bram_we, hebb_gnt, cfg_gnt, wr_freeze}, 32'd0);
      chk("rst_rvalid", {30'd0, core_rvalid, hebb_rvalid}, 32'd0);
      chk("rst_data", {core_rdata, hebb_rdata}, 32'd0);
      chk("rst_bram_bus", {6'd0, bram_addr, bram_wdata}, 32'd0);
    end
    nxt();
    core_req = 1'b0; hebb_req = 1'b0; cfg_req = 1'b0; ad_guard_active = 1'b0;
    rst_n = 1'b1;
    nxt();

    // Core read latency and hold.
    nxt();
    core_req = 1'b1; core_addr = 10'd5;
    nxt();
    core_req = 1'b0;
    #2 chk("core_issue", {bram_en, bram_we, 20'd0, bram_addr}, {2'b10, 20'd0, 10'd5});
    nxt();
    #2 chk("core_rv_t2", 32'(core_rvalid), 32'd0);
    nxt();
    #2 chk("core_rv_t3", 32'(core_rvalid), 32'd1);
    chk("core_data", 32'(core_rdata), 32'h1234);
    nxt();
    #2 chk("core_rv_t4", 32'(core_rvalid), 32'd0);
    chk("core_hold", 32'(core_rdata), 32'h1234);

    // Three-way contention.
    nxt();
    core_req = 1'b1; core_addr = 10'd1;
    hebb_req = 1'b1; hebb_we = 1'b0; hebb_addr = 10'd2;
    cfg_req = 1'b1; cfg_addr = 10'd3; cfg_wdata = 16'hBEEF;
    #2 chk("cont_t0_gnt", {30'd0, hebb_gnt, cfg_gnt}, 32'b00);
    nxt();
    core_req = 1'b0;
    #2 chk("cont_t1_addr", 32'(bram_addr), 32'd1);
    chk("cont_t1_gnt", {30'd0, hebb_gnt, cfg_gnt}, 32'b10);
    nxt();
    hebb_req = 1'b0;
    #2 chk("cont_t2_addr", 32'(bram_addr), 32'd2);
    chk("cont_t2_gnt", {30'd0, hebb_gnt, cfg_gnt}, 32'b01);
    nxt();
    cfg_req = 1'b0;
    #2 chk("cont_t3_wr", {bram_we, 5'd0, bram_addr, bram_wdata}, {1'b1, 5'd0, 10'd3, 16'hBEEF});
    chk("cont_core_rv", {15'd0, core_rvalid, core_rdata}, {15'd0, 1'b1, 16'h0101});
    chk("cont_t3_hrv", 32'(hebb_rvalid), 32'd0);
    nxt();
    #2 chk("cont_t4_hrv", {15'd0, hebb_rvalid, hebb_rdata}, {15'd0, 1'b1, 16'hA5A5});
    nxt();
    #2 chk("cont_t5_hrv", 32'(hebb_rvalid), 32'd0);

    freeze_seq(1'b0, 10'd7, 16'h7777);
    freeze_seq(1'b1, 10'd8, 16'h8888);

    aging(1'b0);
    aging(1'b1);

    // Reset while a core read is in flight.
    nxt();
    core_req = 1'b1; core_addr = 10'd5;
    nxt();
    core_req = 1'b0;
    nxt();
    rst_n = 1'b0;
    #2 chk("mid_rst_rv", 32'(core_rvalid), 32'd0);
    chk("mid_rst_data", 32'(core_rdata), 32'd0);
    chk("mid_rst_en", 32'(bram_en), 32'd0);
    nxt();
    #2 chk("mid_rst_rv2", 32'(core_rvalid), 32'd0);
    nxt();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #2 chk("post_rst_no_rv", 32'(core_rvalid), 32'd0);
      nxt();
    end

    // Resume: write-then-read in consecutive grants, plus earlier writes.
    cfg_req = 1'b1; cfg_addr = 10'd20; cfg_wdata = 16'h2020;
    #2 chk("wtr_cfg_gnt", 32'(cfg_gnt), 32'd1);
    nxt();
    cfg_req = 1'b0;
    core_req = 1'b1; core_addr = 10'd20;
    nxt();
    core_addr = 10'd3;
    nxt();
    core_addr = 10'd7;
    nxt();
    core_addr = 10'd9;
    #2 chk("wtr_data", {15'd0, core_rvalid, core_rdata}, {15'd0, 1'b1, 16'h2020});
    nxt();
    core_req = 1'b0;
    #2 chk("rd_cfg_beef", 32'(core_rdata), 32'hBEEF);
    nxt();
    #2 chk("rd_hebb_wr", 32'(core_rdata), 32'h7777);
    nxt();
    #2 chk("rd_aged_cfg", {15'd0, core_rvalid, core_rdata}, {15'd0, 1'b1, 16'h0909});
    nxt();
    #2 chk("rd_done", 32'(core_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
